// File: rtl/ps2_pkg.sv
// PS/2 keyboard receiver shared types and frame constants.
// Optional parity checking is enabled with PS2_PARITY_CHECK_EN.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  function automatic logic odd_ok(
    input logic [7:0] d,
    input logic       p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Scan-code byte FIFO with sticky overflow and registered head output.
// A pop and a push on a full queue both proceed; the count is unchanged.
module ps2_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop_req,
  input  logic             clr,
  output logic [WIDTH-1:0] dout,
  output logic             ready,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             rdy_q, rdy_d;
  logic             full, empty;
  logic             pop, acc, drop;

  always_comb begin
    full  = cnt_q == (AW+1)'(DEPTH);
    empty = cnt_q == '0;
    pop   = pop_req & ~empty;
    acc   = push & (~full | pop);
    drop  = push & full & ~pop;
    rd_d  = rd_q + AW'(pop);
    wr_d  = wr_q + AW'(acc);
    cnt_d = cnt_q + (AW+1)'(acc)
                  - (AW+1)'(pop);
    ovf_d = drop ? 1'b1 :
            clr  ? 1'b0 : ovf_q;
    rdy_d = cnt_d != '0;
    // Head is precomputed so dout is a flop.
    if (cnt_d == '0)
      dout_d = '0;
    else if (acc && wr_q == rd_d)
      dout_d = din;
    else
      dout_d = mem_q[rd_d];
  end

  always_ff @(posedge clk) begin
    if (acc) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      dout_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      dout_q <= dout_d;
      rdy_q  <= rdy_d;
    end
  end

  assign dout     = dout_q;
  assign ready    = rdy_q;
  assign overflow = ovf_q;

endmodule

// File: rtl/ps2_kbd.sv
// PS/2 keyboard receiver: pin sync, frame FSM, timeout, byte FIFO.
// Define PS2_PARITY_CHECK_EN to drop odd-parity failures.
module ps2_kbd
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 25000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       rd,
  input  logic       clr,
  output logic [7:0] kbd_data,
  output logic       kbd_ready,
  output logic       kbd_overflow,
  output logic       parity_err
);

  localparam int TW = $clog2(TIMEOUT);

  logic          c_s1_q, c_s2_q, c_h_q;
  logic          d_s1_q, d_s2_q;
  logic          fall_q, fall_d;
  logic          bit_q, bit_d;
  ps2_state_e    state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    sr_q, sr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;
  logic          stop_ev, par_good;
  logic          push;
  logic          perr_d;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      c_s1_q <= 1'b1;
      c_s2_q <= 1'b1;
      c_h_q  <= 1'b1;
      d_s1_q <= 1'b1;
      d_s2_q <= 1'b1;
      fall_q <= 1'b0;
      bit_q  <= 1'b1;
    end else begin
      c_s1_q <= ps2_clk;
      c_s2_q <= c_s1_q;
      c_h_q  <= c_s2_q;
      d_s1_q <= ps2_dat;
      d_s2_q <= d_s1_q;
      fall_q <= fall_d;
      bit_q  <= bit_d;
    end
  end

  always_comb begin
    fall_d = c_h_q & ~c_s2_q;
    bit_d  = d_s2_q;
  end

  always_ff @(posedge clock) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  assign tmo_hit = (state_q != IDLE) &&
                   (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (fall_q && bit_q == START_BIT)
          state_d = DATA;
      DATA:
        if (fall_q &&
            bcnt_q == 3'(DATA_BITS - 1))
          state_d = PARITY;
      PARITY:
        if (fall_q) state_d = STOP;
      STOP:
        if (fall_q) state_d = IDLE;
    endcase
    if (tmo_hit) state_d = IDLE;
  end

  always_comb begin
    bcnt_d = bcnt_q;
    sr_d   = sr_q;
    if (state_q == IDLE)
      bcnt_d = '0;
    else if (state_q == DATA && fall_q) begin
      bcnt_d = bcnt_q + 3'd1;
      sr_d   = {bit_q, sr_q[7:1]};
    end
    tmo_d = (fall_q || state_q == IDLE) ?
            '0 : tmo_q + TW'(1);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      bcnt_q <= '0;
      sr_q   <= '0;
      tmo_q  <= '0;
    end else begin
      bcnt_q <= bcnt_d;
      sr_q   <= sr_d;
      tmo_q  <= tmo_d;
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic par_q, par_d;
  logic perr_q;

  always_comb begin
    par_d = par_q;
    if (state_q == PARITY && fall_q)
      par_d = bit_q;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign par_good   = odd_ok(sr_q, par_q);
  assign parity_err = perr_q;
`else
  assign par_good   = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_comb begin
    stop_ev = (state_q == STOP) && fall_q &&
              (bit_q == STOP_BIT) && !tmo_hit;
    push    = stop_ev & par_good;
    perr_d  = stop_ev & ~par_good;
  end

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk      (clock),
    .rstn     (resetn),
    .push     (push),
    .din      (sr_q),
    .pop_req  (rd),
    .clr      (clr),
    .dout     (kbd_data),
    .ready    (kbd_ready),
    .overflow (kbd_overflow)
  );

endmodule

// File: tb/tb_ps2_kbd.sv
// Scoreboard bench for ps2_kbd: random frames against a queue model.
// Parity expectations follow PS2_PARITY_CHECK_EN.
module tb_ps2_kbd;

  localparam int DEPTH = 8;
  localparam int TMO   = 200;
  localparam int H     = 10;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       rd = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       kbd_overflow;
  logic       parity_err;

  ps2_kbd #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TMO)
  ) dut (
    .clock        (clock),
    .resetn       (resetn),
    .ps2_clk      (ps2_clk),
    .ps2_dat      (ps2_dat),
    .rd           (rd),
    .clr          (clr),
    .kbd_data     (kbd_data),
    .kbd_ready    (kbd_ready),
    .kbd_overflow (kbd_overflow),
    .parity_err   (parity_err)
  );

  always #20 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int perr_exp = 0;
  int perr_seen = 0;
  bit ovf_exp = 1'b0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name,
                     input int act,
                     input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h",
               name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #5;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    cyc(H);
    ps2_clk = 1'b0;
    cyc(H);
    ps2_clk = 1'b1;
  endtask

  // Ends with ps2_clk just driven low on the stop bit.
  task automatic send_head(input logic [7:0] d,
                           input bit pbad,
                           input bit stop_v);
    logic p;
    p = ~^d;
    if (pbad) p = ~p;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(p);
    ps2_dat = stop_v;
    cyc(H);
    ps2_clk = 1'b0;
  endtask

  task automatic send_tail();
    cyc(H);
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    cyc(H);
  endtask

  task automatic model_frame(input logic [7:0] d,
                             input bit pbad,
                             input bit stop_v);
    if (!stop_v) return;
    if (PCHK && pbad) perr_exp++;
    else if (exp_q.size() < DEPTH)
      exp_q.push_back(d);
    else ovf_exp = 1'b1;
  endtask

  task automatic send(input logic [7:0] d,
                      input bit pbad,
                      input bit stop_v);
    send_head(d, pbad, stop_v);
    send_tail();
    model_frame(d, pbad, stop_v);
  endtask

  task automatic read1();
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_ready"}, kbd_ready,
        exp_q.size() != 0);
    chk({tag, "_data"}, kbd_data,
        exp_q.size() != 0 ? exp_q[0] : 0);
    chk({tag, "_ovf"}, kbd_overflow, ovf_exp);
    chk({tag, "_perr"}, perr_seen, perr_exp);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 64) begin
      read1();
      guard++;
    end
    cyc(1);
    chk_state(tag);
  endtask

  always @(negedge clock) begin
    if (parity_err) perr_seen++;
    if (rd && resetn) begin
      if (exp_q.size() == 0) begin
        chk("rd_empty_ready", kbd_ready, 0);
        chk("rd_empty_data", kbd_data, 0);
      end else begin
        chk("pop_data", kbd_data,
            exp_q.pop_front());
      end
    end
  end

  initial begin
    #(40 * 90000);
    $display("FAIL watchdog act=timeout req=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    bit pb, sb;
    resetn = 1'b0;
    cyc(3);
    chk("rst_data", kbd_data, 0);
    chk("rst_ready", kbd_ready, 0);
    chk("rst_ovf", kbd_overflow, 0);
    chk("rst_perr", parity_err, 0);
    resetn = 1'b1;
    cyc(2);

    // Stop-edge latency: visible after the 4th edge.
    send_head(8'h1C, 1'b0, 1'b1);
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("lat3_ready", kbd_ready, 0);
    @(posedge clock);
    @(negedge clock);
    chk("lat4_ready", kbd_ready, 1);
    chk("lat4_data", kbd_data, 8'h1C);
    @(posedge clock);
    #5;
    send_tail();
    model_frame(8'h1C, 1'b0, 1'b1);
    read1();
    cyc(1);
    chk_state("after_pop");

    for (int i = 1; i <= 9; i++)
      send(8'(i), 1'b0, 1'b1);
    chk_state("overflow");
    drain("ovf_drain");
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    ovf_exp = 1'b0;
    cyc(1);
    chk_state("clr");

    // Full FIFO with pop landing on the push cycle.
    for (int i = 0; i < DEPTH; i++)
      send(8'($urandom), 1'b0, 1'b1);
    b = 8'h5A;
    send_head(b, 1'b0, 1'b1);
    cyc(3);
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
    send_tail();
    model_frame(b, 1'b0, 1'b1);
    chk("coll_count", exp_q.size(), DEPTH);
    chk_state("collide");
    drain("coll_drain");

    send(8'h1C, 1'b1, 1'b1);
    chk_state("parity");
    drain("par_drain");

    // Partial frame abandoned by the timeout.
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    cyc(TMO + 20);
    send(8'hF0, 1'b0, 1'b1);
    chk_state("timeout");
    drain("tmo_drain");

    for (int i = 0; i < 3; i++)
      send(8'($urandom), 1'b0, 1'b1);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b0);
    resetn = 1'b0;
    cyc(1);
    chk("mrst_data", kbd_data, 0);
    chk("mrst_ready", kbd_ready, 0);
    chk("mrst_ovf", kbd_overflow, 0);
    chk("mrst_perr", parity_err, 0);
    exp_q.delete();
    ovf_exp = 1'b0;
    resetn = 1'b1;
    cyc(2);
    send(8'hAA, 1'b0, 1'b1);
    chk_state("post_rst");
    drain("post_rst_drain");

    for (int i = 0; i < 30; i++) begin
      b  = 8'($urandom);
      pb = ($urandom_range(3) == 0);
      sb = ($urandom_range(7) != 0);
      send(b, pb, sb);
      chk_state("rnd");
      repeat ($urandom_range(2)) read1();
    end
    drain("rnd_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
